// File: rtl/calc_pkg.sv
// Shared types and constants for the add/subtract calculator lab.
package calc_pkg;

    // Calculator phases; the encoding is visible on state_out.
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        COMPUTE = 2'd2,
        SHOW    = 2'd3
    } state_t;

    // Bit positions inside digit_en.
    localparam int DIGIT_A   = 0;
    localparam int DIGIT_B   = 1;
    localparam int DIGIT_RES = 2;
    localparam int DIGIT_SYM = 3;

    // DE10-Lite board oscillator.
    localparam int CLK_HZ = 50_000_000;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/calc_key_debounce.sv
// Pushbutton conditioning: synchronizer, stability counter and press pulse.
module key_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic: a level change is accepted only after it has been
    // stable long enough; a key already held through reset stays ignored
    // until it has been seen released once.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        armed_d = armed_q | sync2_q;
        press_d = armed_q & level_q & ~level_d;
    end

    // Registers, with the synchronizer parked at "pressed" so a held key
    // cannot arm the press detector out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Phase sequencer for the 4-bit add/subtract lab: operand entry, adder
// handshake, result capture and display enables.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 12500000,
    parameter int ADDER_LAT       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_n,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] sw_val,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             s,
    output logic [WIDTH-1:0] result,
    output logic             result_carry,
    output logic [1:0]       state_out,
    output logic [3:0]       digit_en,
    output logic             busy
);

    localparam int DIV_W = cnt_width(BLINK_DIV);
    localparam int LAT_W = cnt_width(ADDER_LAT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ADDER_LAT - 1);
    localparam logic [3:0] EN_RESET = 4'b1001;

    logic press;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             blink_q, blink_d;
    logic [3:0]       digit_en_q, digit_en_d;
    logic             busy_q, busy_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk    (clk),
        .reset_n(reset_n),
        .key_n  (key_n),
        .press  (press)
    );

    // Phase transitions, operand tracking/freezing, adder wait and the
    // blink divider, followed by the display enables for the next phase.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        result_d = result_q;
        carry_d  = carry_q;
        lat_d    = lat_q;
        div_d    = div_q;
        blink_d  = blink_q;

        case (state_q)
            ENTER_A: begin
                a_d = sw_val;
                if (press) begin
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                b_d = sw_val;
                s_d = op_sel;
                if (press) begin
                    state_d = COMPUTE;
                    lat_d   = LAT_LOAD;
                end
            end
            COMPUTE: begin
                if (lat_q == '0) begin
                    result_d = sum;
                    carry_d  = carry_in;
                    state_d  = SHOW;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            SHOW: begin
                if (press) begin
                    state_d  = ENTER_A;
                    result_d = '0;
                    carry_d  = 1'b0;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase

        if (state_d != state_q) begin
            div_d   = '0;
            blink_d = 1'b1;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            blink_d = ~blink_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        digit_en_d = '0;
        case (state_d)
            ENTER_A: begin
                digit_en_d[DIGIT_SYM] = 1'b1;
                digit_en_d[DIGIT_A]   = blink_d;
            end
            ENTER_B: begin
                digit_en_d[DIGIT_SYM] = 1'b1;
                digit_en_d[DIGIT_A]   = 1'b1;
                digit_en_d[DIGIT_B]   = blink_d;
            end
            COMPUTE: begin
                digit_en_d[DIGIT_SYM] = 1'b1;
                digit_en_d[DIGIT_A]   = 1'b1;
                digit_en_d[DIGIT_B]   = 1'b1;
            end
            default: begin
                digit_en_d = 4'b1111;
            end
        endcase

        busy_d = (state_d == COMPUTE);
    end

    // Sequencer registers; reset drops straight back to operand A entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ENTER_A;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            lat_q      <= '0;
            div_q      <= '0;
            blink_q    <= 1'b1;
            digit_en_q <= EN_RESET;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s_q        <= s_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            lat_q      <= lat_d;
            div_q      <= div_d;
            blink_q    <= blink_d;
            digit_en_q <= digit_en_d;
            busy_q     <= busy_d;
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign s            = s_q;
    assign result       = result_q;
    assign result_carry = carry_q;
    assign state_out    = state_q;
    assign digit_en     = digit_en_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural adder.
module tb_calc_sequencer;

    localparam int LAT = 1;

    logic       clk;
    logic       reset_n;
    logic       key_n;
    logic       key4_n;
    logic       op_sel;
    logic [3:0] sw_val;

    logic [3:0] sum, a, b, result;
    logic       carry_in, s, result_carry, busy;
    logic [1:0] state_out;
    logic [3:0] digit_en;

    logic [3:0] sum4, a4, b4, result4;
    logic       carry4_in, s4, result_carry4, busy4;
    logic [1:0] state4;
    logic [3:0] digit_en4;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct packed {
        logic [3:0] opA;
        logic [3:0] opB;
        logic       op;
        logic [3:0] expRes;
        logic       expCarry;
    } vec_t;

    vec_t vecs [9];

    // Lab arithmetic: add gives carry-out; subtract gives a-b with carry
    // flagging a borrow (a < b).
    function automatic logic [4:0] modelCalc(input logic [3:0] x, input logic [3:0] y, input logic sub);
        int r;
        if (sub) begin
            r = int'(x) - int'(y);
            return {(r < 0), 4'(r)};
        end
        r = int'(x) + int'(y);
        return {(r > 15), 4'(r)};
    endfunction

    assign {carry_in, sum}   = modelCalc(a, b, s);
    assign {carry4_in, sum4} = modelCalc(a4, b4, s4);

    calc_sequencer #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8), .ADDER_LAT(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_n(key_n), .op_sel(op_sel),
        .sw_val(sw_val), .sum(sum), .carry_in(carry_in), .a(a), .b(b), .s(s),
        .result(result), .result_carry(result_carry), .state_out(state_out),
        .digit_en(digit_en), .busy(busy)
    );

    calc_sequencer #(
        .WIDTH(4), .DEBOUNCE_CYCLES(1), .BLINK_DIV(8), .ADDER_LAT(4)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .key_n(key4_n), .op_sel(op_sel),
        .sw_val(sw_val), .sum(sum4), .carry_in(carry4_in), .a(a4), .b(b4), .s(s4),
        .result(result4), .result_carry(result_carry4), .state_out(state4),
        .digit_en(digit_en4), .busy(busy4)
    );

    // 100 MHz-style bench clock; the period itself is irrelevant here.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never settles.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hold the main key down until the phase changes; optionally scramble the
    // switches every cycle and report what was on them at the accepting edge.
    task automatic pressKey(input bit jitter, output logic [3:0] swSampled, output logic opSampled);
        logic [1:0] old;
        bit done;
        old = state_out;
        done = 0;
        key_n = 1'b0;
        swSampled = sw_val;
        opSampled = op_sel;
        for (int i = 0; i < 40 && !done; i++) begin
            if (jitter) begin
                sw_val = 4'($urandom_range(0, 15));
                op_sel = 1'($urandom_range(0, 1));
            end
            swSampled = sw_val;
            opSampled = op_sel;
            @(negedge clk);
            if (state_out != old) done = 1;
        end
        checkOutput("pressAdvance", 32'(done), 32'd1);
    endtask

    task automatic releaseKey();
        key_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // One full calculation, from ENTER_A through SHOW and back.
    task automatic applyStimulus(input logic [3:0] opA, input logic [3:0] opB, input logic op,
                                 input logic [3:0] expRes, input logic expCarry, input bit jitter);
        logic [3:0] sA, sB;
        logic       sOp, dummy;
        logic [4:0] exp;
        int         n;
        checkOutput("startInA", state_out, 0);
        if (!jitter) begin
            sw_val = opA;
            op_sel = ~op;
            @(negedge clk);
        end
        pressKey(jitter, sA, dummy);
        checkOutput("enterB", state_out, 1);
        checkOutput("aFrozen", a, sA);
        checkOutput("bLitOnEntry", digit_en, 4'b1011);
        releaseKey();
        checkOutput("aHeld", a, sA);
        if (!jitter) begin
            sw_val = opB;
            op_sel = op;
            @(negedge clk);
        end
        pressKey(jitter, sB, sOp);
        checkOutput("computeState", state_out, 2);
        checkOutput("busyInCompute", busy, 1);
        checkOutput("computeDigits", digit_en, 4'b1011);
        n = 0;
        while (state_out == 2 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("computeCycles", n, LAT);
        exp = jitter ? modelCalc(sA, sB, sOp) : {expCarry, expRes};
        checkOutput("showState", state_out, 3);
        checkOutput("result", result, exp[3:0]);
        checkOutput("resultCarry", result_carry, exp[4]);
        checkOutput("bFrozen", b, sB);
        checkOutput("sFrozen", s, jitter ? sOp : op);
        checkOutput("showDigits", digit_en, 4'b1111);
        checkOutput("busyInShow", busy, 0);
        releaseKey();
        pressKey(0, sA, dummy);
        checkOutput("backToA", state_out, 0);
        checkOutput("resultCleared", result, 0);
        checkOutput("carryCleared", result_carry, 0);
        releaseKey();
    endtask

    initial begin
        int changes;
        int cc;
        logic [1:0] prev;
        logic [3:0] prevSw;
        logic [3:0] junkSw;
        logic       junkOp;

        vecs[0] = '{4'd5,  4'd9,  1'b0, 4'hE, 1'b0};
        vecs[1] = '{4'd3,  4'd7,  1'b1, 4'hC, 1'b1};
        vecs[2] = '{4'd15, 4'd1,  1'b0, 4'h0, 1'b1};
        vecs[3] = '{4'd8,  4'd8,  1'b0, 4'h0, 1'b1};
        vecs[4] = '{4'd7,  4'd3,  1'b1, 4'h4, 1'b0};
        vecs[5] = '{4'd0,  4'd0,  1'b1, 4'h0, 1'b0};
        vecs[6] = '{4'd15, 4'd15, 1'b1, 4'h0, 1'b0};
        vecs[7] = '{4'd0,  4'd1,  1'b1, 4'hF, 1'b1};
        vecs[8] = '{4'd15, 4'd15, 1'b0, 4'hE, 1'b1};

        reset_n = 1'b0;
        key_n   = 1'b0;
        key4_n  = 1'b1;
        op_sel  = 1'b0;
        sw_val  = 4'd0;

        // Reset with the key held: values, then no press until a release.
        repeat (3) @(negedge clk);
        checkOutput("rstState", state_out, 0);
        checkOutput("rstA", a, 0);
        checkOutput("rstB", b, 0);
        checkOutput("rstS", s, 0);
        checkOutput("rstResult", result, 0);
        checkOutput("rstCarry", result_carry, 0);
        checkOutput("rstDigits", digit_en, 4'b1001);
        checkOutput("rstBusy", busy, 0);
        reset_n = 1'b1;
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (state_out != 0) changes++;
        end
        checkOutput("heldThroughReset", changes, 0);
        releaseKey();
        pressKey(0, junkSw, junkOp);
        checkOutput("pressAfterRelease", state_out, 1);
        releaseKey();

        // Blink cadence and A tracking straight out of reset.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        prevSw = 4'd0;
        for (int n = 0; n < 32; n++) begin
            checkOutput("blinkA", digit_en, ((n / 8) % 2 == 0) ? 4'b1001 : 4'b1000);
            if (n > 0) checkOutput("aTracks", a, prevSw);
            sw_val = 4'(n);
            prevSw = sw_val;
            @(negedge clk);
        end

        // Table of directed calculations.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].op, vecs[i].expRes, vecs[i].expCarry, 0);
        end

        // Randomized calculations with switches changing every cycle.
        for (int k = 0; k < 12; k++) begin
            applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1);
        end

        // Bouncing key then a long hold: exactly one advance.
        sw_val = 4'd1;
        op_sel = 1'b0;
        key_n  = 1'b1;
        @(negedge clk);
        changes = 0;
        prev = state_out;
        for (int i = 0; i < 120; i++) begin
            if (i < 20 && i % 2 == 0) key_n = ~key_n;
            if (i >= 20) key_n = 1'b0;
            @(negedge clk);
            if (state_out != prev) changes++;
            prev = state_out;
        end
        checkOutput("bounceAdvances", changes, 1);
        checkOutput("bounceState", state_out, 1);
        checkOutput("bounceA", a, 1);
        releaseKey();

        // Reach SHOW, then a one-cycle reset aborts everything.
        sw_val = 4'd4;
        @(negedge clk);
        pressKey(0, junkSw, junkOp);
        cc = 0;
        while (state_out != 3 && cc < 20) begin
            cc++;
            @(negedge clk);
        end
        checkOutput("midShow", state_out, 3);
        checkOutput("midResult", result, 4'd5);
        releaseKey();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("midRstState", state_out, 0);
        checkOutput("midRstResult", result, 0);
        checkOutput("midRstCarry", result_carry, 0);
        sw_val = 4'd2;
        @(negedge clk);
        pressKey(0, junkSw, junkOp);
        checkOutput("postRstEnterB", state_out, 1);
        checkOutput("postRstA", a, 2);
        releaseKey();

        // ADDER_LAT=4 instance: a second press landing in COMPUTE is dropped.
        sw_val = 4'd6;
        @(negedge clk);
        key4_n = 1'b0;
        cc = 0;
        while (state4 != 1 && cc < 20) begin
            cc++;
            @(negedge clk);
        end
        checkOutput("lat4EnterB", state4, 1);
        key4_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("lat4A", a4, 6);
        sw_val = 4'd3;
        op_sel = 1'b1;
        @(negedge clk);
        cc = 0;
        for (int i = 0; i < 40; i++) begin
            key4_n = (i == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (state4 == 2) cc++;
            if (state4 == 3) break;
        end
        checkOutput("lat4ComputeCycles", cc, 4);
        checkOutput("lat4Show", state4, 3);
        checkOutput("lat4Result", result4, 4'd3);
        checkOutput("lat4Carry", result_carry4, 0);
        checkOutput("lat4Digits", digit_en4, 4'b1111);
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (state4 != 3 || busy4 != 1'b0) changes++;
        end
        checkOutput("lat4DroppedPress", changes, 0);
        key4_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Sequences the 4-bit add/subtract datapath and its HEX symbol display on the DE10-Lite lab board.
- One pushbutton steps the user through three phases: enter operand A, enter operand B plus the operation, then show the result.
- Drives the adder's operand and select inputs, waits a fixed latency, captures sum and carry, and generates per-digit blank/blink enables for the display logic.

Parameters:
- WIDTH, 4, operand/result width in bits
- DEBOUNCE_CYCLES, 500000, cycles the synchronized key level must be stable before it is accepted (10 ms at 50 MHz)
- BLINK_DIV, 12500000, half-period in cycles of the entry-digit blink
- ADDER_LAT, 1, cycles from operands stable to sum/carry valid

Ports:
- clk  input  1  board clock, 50 MHz
- reset_n  input  1  synchronous active-low reset
- key_n  input  1  raw pushbutton, active-low, asynchronous to clk
- op_sel  input  1  slide switch: 0 = add, 1 = subtract
- sw_val  input  WIDTH  slide-switch operand value
- sum  input  WIDTH  adder result
- carry_in  input  1  carry out from the adder
- a  output  WIDTH  operand A to the adder
- b  output  WIDTH  operand B to the adder
- s  output  1  operation select to the adder and symbol logic
- result  output  WIDTH  captured result
- result_carry  output  1  captured carry; feeds the symbol logic's carryOut
- state_out  output  2  current state encoding
- digit_en  output  4  display enables: [0] A digit, [1] B digit, [2] result digits, [3] symbols (+/-, =); 1 = lit
- busy  output  1  high in COMPUTE

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous, active-low, and sampled on the clk rising edge.
  - Reset values: a=0, b=0, s=0, result=0, result_carry=0, state=ENTER_A, busy=0, blink phase=1, debounce counter=0.
  - Debounced key level resets to released (1).
  - Reset asserted mid-operation aborts immediately to these values.
- Key input path:
  - 2-flop synchronizer on key_n.
  - The debounce counter increments while the synchronized level differs from the debounced level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level updates and the counter clears.
  - press = a one-cycle pulse on the debounced 1->0 transition. Release generates nothing. Holding the key generates exactly one press.
- States (state_out encoding):
  - ENTER_A (0): a follows sw_val every cycle. digit_en=4'b1001 with bit0 ANDed with blink. On press, a freezes at the current sw_val, go to ENTER_B.
  - ENTER_B (1): b follows sw_val and s follows op_sel. digit_en=4'b1011 with bit1 ANDed with blink. On press, b and s freeze, go to COMPUTE.
  - COMPUTE (2): busy=1, digit_en=4'b1011. A latency counter loads ADDER_LAT-1 on entry. When it reaches 0, result<=sum and result_carry<=carry_in in the same cycle, go to SHOW. Presses during COMPUTE are dropped.
  - SHOW (3): digit_en=4'b1111, no blink; a, b, s, result and result_carry hold. On press, go to ENTER_A, clear result and result_carry to 0, and the blink phase restarts at 1.
- Timing:
  - Every transition takes effect one cycle after the press pulse.
  - Total from the B-press pulse to result valid is ADDER_LAT+1 cycles.
- Blink:
  - A free-running divider toggles the blink phase each BLINK_DIV cycles and wraps to 0.
  - The divider is reset on every state entry, so the newly active digit is lit immediately.
- Widths and arithmetic:
  - result is the raw WIDTH-bit sum; no sign extension or clamping.
  - All counters are sized by $clog2 of their parameter, with a minimum of 1 bit.
- Boundary conditions:
  - A press coincident with reset is ignored.
  - op_sel or sw_val changing in the same cycle as a press: the value sampled in that cycle is frozen.

Decomposition:
- Package calc_pkg holds:
  - state typedef {ENTER_A, ENTER_B, COMPUTE, SHOW}
  - digit_en bit-index constants
  - board constant CLK_HZ=50_000_000
- Sub-module key_debounce (params DEBOUNCE_CYCLES): synchronizer, counter and press pulse. It is reused by later labs.
- The FSM, latency counter and blink divider stay in calc_sequencer.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, BLINK_DIV=8, ADDER_LAT=1, with a bench adder model.
- Reset: hold reset_n=0 for 3 cycles with key_n=0 -> state_out=0, a=b=0, s=0, result=0, digit_en[3]=1, and no press after release of reset until key_n goes 1 then 0.
- Add path: sw_val=5, press; sw_val=9, op_sel=0, press -> after 2 cycles state_out=3, result=4'hE, result_carry=0, s=0.
- Subtract with carry: A=3, B=7, op_sel=1 (adder model gives sum=4'hC, carry=1) -> result=4'hC, result_carry=1, s=1.
- Bounce: toggle key_n every 2 cycles for 20 cycles, then hold 0 -> exactly one state advance. Holding key_n=0 for 100 cycles -> no further advance.
- Blink and entry tracking: in ENTER_A, digit_en[0] toggles every 8 cycles and a tracks sw_val=0..15 each cycle. A press in COMPUTE (ADDER_LAT=4 run) is dropped.
- Mid-op reset: reset_n=0 for 1 cycle while in SHOW -> next cycle state_out=0, result=0, result_carry=0. A new A=2 entry then proceeds normally.
